video720_timing_gen: RTL

- Consumer of the 74.25 MHz pixel clock produced by the video PLL.
- Qualifies the PLL lock indication, then generates 1280x720@60 raster timing (hsync, vsync, de).
- Issues a pixel fetch request to the framebuffer reader and returns the fetched RGB pixel aligned to the timing outputs.
- Sits between the PLL/framebuffer and the HDMI/VGA output stage.

---
 rtl/video720_timing_gen.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/video720_timing_gen.sv
// video720_timing_gen
// 1280x720@60 raster timing generator on the 74.25 MHz pixel clock.
// Qualifies PLL lock, issues framebuffer pixel requests and returns the
// fetched RGB aligned two clocks later with hsync/vsync/de.
// Optional build macro: VIDEO720_TEST_PATTERN_EN replaces the framebuffer
// path with eight internal vertical colour bars.
module video720_timing_gen #(
    parameter int unsigned H_ACTIVE    = 1280,
    parameter int unsigned H_FP        = 110,
    parameter int unsigned H_SYNC      = 40,
    parameter int unsigned H_BP        = 220,
    parameter int unsigned V_ACTIVE    = 720,
    parameter int unsigned V_FP        = 5,
    parameter int unsigned V_SYNC      = 5,
    parameter int unsigned V_BP        = 20,
    parameter bit          SYNC_POL    = 1'b1,
    parameter int unsigned LOCK_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_locked,
    output logic        pix_req,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    input  logic [23:0] pix_data,
    output logic        vid_de,
    output logic        vid_hs,
    output logic        vid_vs,
    output logic [23:0] vid_rgb,
    output logic        frame_start,
    output logic        running
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam int unsigned SW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_t;

    state_t        state;
    logic [10:0]   h;
    logic [9:0]    v;
    logic [SW-1:0] settle;

    logic raw_de, raw_hs, raw_vs, raw_first;
    logic live;

    logic s1_de, s1_hs, s1_vs, s1_first;
    logic s2_de, s2_hs, s2_vs, s2_first;
    logic [23:0] src_rgb;

    // Raw timing decode of the current counter position.
    always_comb begin
        raw_de    = (h < H_ACT) && (v < V_ACT);
        raw_hs    = (h >= HS_BEG) && (h < HS_END);
        raw_vs    = (v >= VS_BEG) && (v < VS_END);
        raw_first = (h == '0) && (v == '0);
        live      = (state == RUN) && pll_locked;
    end

    // Lock qualification FSM and raster counters; running tracks RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_LOCK;
            h       <= '0;
            v       <= '0;
            settle  <= '0;
            running <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    settle <= '0;
                    if (pll_locked) state <= SETTLE;
                end
                SETTLE: begin
                    if (!pll_locked) begin
                        state  <= WAIT_LOCK;
                        settle <= '0;
                    end else if (settle == SETTLE_LAST) begin
                        state   <= RUN;
                        h       <= '0;
                        v       <= '0;
                        running <= 1'b1;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                RUN: begin
                    if (!pll_locked) begin
                        state   <= WAIT_LOCK;
                        settle  <= '0;
                        running <= 1'b0;
                    end else if (h == H_LAST) begin
                        h <= '0;
                        v <= (v == V_LAST) ? '0 : v + 1'b1;
                    end else begin
                        h <= h + 1'b1;
                    end
                end
                default: begin
                    state   <= WAIT_LOCK;
                    settle  <= '0;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifdef VIDEO720_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [10:0] s1_x, s2_x;
    logic [2:0]  bar_idx;
    logic        unused_pix_data;

    assign unused_pix_data = ^pix_data;

    // Bar colour from the delayed column; a compare ladder keeps each bar exactly H_ACTIVE/8 wide.
    always_comb begin
        bar_idx = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (32'(s2_x) >= i * BAR_W) bar_idx = 3'(i);
        end
        case (bar_idx)
            3'd0:    src_rgb = 24'hFFFFFF;
            3'd1:    src_rgb = 24'hFFFF00;
            3'd2:    src_rgb = 24'h00FFFF;
            3'd3:    src_rgb = 24'h00FF00;
            3'd4:    src_rgb = 24'hFF00FF;
            3'd5:    src_rgb = 24'hFF0000;
            3'd6:    src_rgb = 24'h0000FF;
            default: src_rgb = 24'h000000;
        endcase
    end

    // Column delay line feeding the bar selector.
    always_ff @(posedge clk) begin
        if (rst || !live) begin
            s1_x <= '0;
            s2_x <= '0;
        end else begin
            s1_x <= h;
            s2_x <= s1_x;
        end
    end
`else
    // Framebuffer data is valid one clock after the request, i.e. at stage 2.
    always_comb begin
        src_rgb = pix_data;
    end
`endif

    // Request, two-stage timing delay and registered video outputs; flushed whenever not live.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            s1_de       <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_first    <= 1'b0;
            s2_de       <= 1'b0;
            s2_hs       <= 1'b0;
            s2_vs       <= 1'b0;
            s2_first    <= 1'b0;
            vid_de      <= 1'b0;
            vid_hs      <= ~SYNC_POL;
            vid_vs      <= ~SYNC_POL;
            vid_rgb     <= '0;
            frame_start <= 1'b0;
        end else if (!live) begin
            pix_req     <= 1'b0;
            s1_de       <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_first    <= 1'b0;
            s2_de       <= 1'b0;
            s2_hs       <= 1'b0;
            s2_vs       <= 1'b0;
            s2_first    <= 1'b0;
            vid_de      <= 1'b0;
            vid_hs      <= ~SYNC_POL;
            vid_vs      <= ~SYNC_POL;
            vid_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
`ifdef VIDEO720_TEST_PATTERN_EN
            pix_req <= 1'b0;
`else
            pix_req <= raw_de;
`endif
            if (raw_de) begin
                pix_x <= h;
                pix_y <= v;
            end
            s1_de       <= raw_de;
            s1_hs       <= raw_hs;
            s1_vs       <= raw_vs;
            s1_first    <= raw_first;
            s2_de       <= s1_de;
            s2_hs       <= s1_hs;
            s2_vs       <= s1_vs;
            s2_first    <= s1_first;
            vid_de      <= s2_de;
            vid_hs      <= s2_hs ? SYNC_POL : ~SYNC_POL;
            vid_vs      <= s2_vs ? SYNC_POL : ~SYNC_POL;
            vid_rgb     <= s2_de ? src_rgb : '0;
            frame_start <= s2_first;
        end
    end

endmodule
